// File: rtl/miriscv_darb_pkg.sv
// Shared types and constants for the two-port data-bus arbiter.
package miriscv_darb_pkg;

    localparam int unsigned XLEN         = 32;
    localparam int unsigned DARB_N_PORTS = 2;

    typedef enum logic {
        DARB_IDLE = 1'b0,
        DARB_BUSY = 1'b1
    } darb_state_e;

endpackage

// File: rtl/miriscv_rr_arbiter.sv
// Combinational 2-way round-robin pick: on a tie the port that did not own
// the bus last time wins.
module miriscv_rr_arbiter
    import miriscv_darb_pkg::*;
(
    input  logic [DARB_N_PORTS-1:0] req_i,
    input  logic                    last_i,
    output logic [DARB_N_PORTS-1:0] gnt_o
);

    // one-hot grant selection
    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_i ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/miriscv_data_arbiter.sv
// Arbitrates the core LSU (port 0) and debug/DMA (port 1) onto one data bus.
// Optional response timeout is compiled in with MIRISCV_DARB_TIMEOUT_EN.
module miriscv_data_arbiter
    import miriscv_darb_pkg::*;
#(
    parameter int unsigned XLEN           = miriscv_darb_pkg::XLEN,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [XLEN/8-1:0] m0_be_i,
    input  logic [XLEN-1:0]   m0_addr_i,
    input  logic [XLEN-1:0]   m0_wdata_i,
    output logic              m0_rvalid_o,
    output logic [XLEN-1:0]   m0_rdata_o,

    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [XLEN/8-1:0] m1_be_i,
    input  logic [XLEN-1:0]   m1_addr_i,
    input  logic [XLEN-1:0]   m1_wdata_i,
    output logic              m1_rvalid_o,
    output logic [XLEN-1:0]   m1_rdata_o,

    output logic              data_req_o,
    output logic              data_we_o,
    output logic [XLEN/8-1:0] data_be_o,
    output logic [XLEN-1:0]   data_addr_o,
    output logic [XLEN-1:0]   data_wdata_o,
    input  logic              data_rvalid_i,
    input  logic [XLEN-1:0]   data_rdata_i,

    output logic              err_o
);

    darb_state_e       state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic              we_q, we_d;
    logic [XLEN/8-1:0] be_q, be_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;

    logic [1:0]        gnt_s;
    logic              busy_s;
    logic              timeout_s;
    logic              done_s;
    logic              resp_s;

    miriscv_rr_arbiter u_rr (
        .req_i  ({m1_req_i, m0_req_i}),
        .last_i (last_q),
        .gnt_o  (gnt_s)
    );

    assign busy_s = (state_q == DARB_BUSY);

`ifdef MIRISCV_DARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter holds BUSY-cycles-so-far minus one, so the limit fires on the
    // TIMEOUT_CYCLES-th BUSY cycle itself.
    assign timeout_s = busy_s && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // timeout counter next value
    always_comb begin
        cnt_d = cnt_q;
        if (!busy_s) begin
            cnt_d = '0;
        end else if (!data_rvalid_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // timeout counter register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    assign done_s = busy_s && (data_rvalid_i || timeout_s);
    assign resp_s = done_s && !rst_i;

    // next-state, ownership and captured-attribute logic
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        we_d    = we_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            DARB_IDLE: begin
                if (gnt_s != 2'b00) begin
                    state_d = DARB_BUSY;
                    owner_d = gnt_s[1];
                    we_d    = gnt_s[1] ? m1_we_i    : m0_we_i;
                    be_d    = gnt_s[1] ? m1_be_i    : m0_be_i;
                    addr_d  = gnt_s[1] ? m1_addr_i  : m0_addr_i;
                    wdata_d = gnt_s[1] ? m1_wdata_i : m0_wdata_i;
                end else begin
                    state_d = DARB_IDLE;
                end
            end
            DARB_BUSY: begin
                // Attributes are cleared on exit so the bus reads 0 in IDLE.
                if (done_s) begin
                    state_d = DARB_IDLE;
                    last_d  = owner_q;
                    owner_d = 1'b0;
                    we_d    = 1'b0;
                    be_d    = '0;
                    addr_d  = '0;
                    wdata_d = '0;
                end else begin
                    state_d = DARB_BUSY;
                end
            end
            default: begin
                state_d = DARB_IDLE;
            end
        endcase
    end

    // state and attribute registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= DARB_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign data_req_o   = busy_s;
    assign data_we_o    = we_q;
    assign data_be_o    = be_q;
    assign data_addr_o  = addr_q;
    assign data_wdata_o = wdata_q;

    // A timeout response carries zero data; a real rvalid always wins.
    assign m0_rvalid_o = resp_s && !owner_q;
    assign m1_rvalid_o = resp_s &&  owner_q;
    assign m0_rdata_o  = (m0_rvalid_o && data_rvalid_i) ? data_rdata_i : '0;
    assign m1_rdata_o  = (m1_rvalid_o && data_rvalid_i) ? data_rdata_i : '0;
    assign err_o       = resp_s && timeout_s && !data_rvalid_i;

endmodule

// File: tb/tb_miriscv_data_arbiter.sv
// Directed bench for miriscv_data_arbiter (TIMEOUT_CYCLES = 8); the timeout
// scenarios follow MIRISCV_DARB_TIMEOUT_EN.
module tb_miriscv_data_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i;
    logic [3:0]  m0_be_i, m1_be_i;
    logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
    logic        m0_rvalid_o, m1_rvalid_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic        data_req_o, data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o, data_wdata_o;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;
    logic        err_o;

    int n_checks = 0;
    int n_errors = 0;

    miriscv_data_arbiter #(.XLEN(32), .TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i),
        .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
        .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i),
        .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
        .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
        .data_req_o(data_req_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
        .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
        .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i),
        .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // inputs change at the falling edge, outputs are sampled 1ns later
    task automatic step();
        @(negedge clk_i);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        m0_req_i = 1'b0; m0_we_i = 1'b0; m0_be_i = 4'h0; m0_addr_i = 32'h0; m0_wdata_i = 32'h0;
        m1_req_i = 1'b0; m1_we_i = 1'b0; m1_be_i = 4'h0; m1_addr_i = 32'h0; m1_wdata_i = 32'h0;
        data_rvalid_i = 1'b0; data_rdata_i = 32'h0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".req"},    {31'h0, data_req_o},  32'h0);
        chk({tag, ".we"},     {31'h0, data_we_o},   32'h0);
        chk({tag, ".be"},     {28'h0, data_be_o},   32'h0);
        chk({tag, ".addr"},   data_addr_o,          32'h0);
        chk({tag, ".wdata"},  data_wdata_o,         32'h0);
        chk({tag, ".rv0"},    {31'h0, m0_rvalid_o}, 32'h0);
        chk({tag, ".rv1"},    {31'h0, m1_rvalid_o}, 32'h0);
        chk({tag, ".rd0"},    m0_rdata_o,           32'h0);
        chk({tag, ".rd1"},    m1_rdata_o,           32'h0);
        chk({tag, ".err"},    {31'h0, err_o},       32'h0);
    endtask

    task automatic do_reset();
        step();
        rst_i = 1'b1;
        idle_inputs();
        step();
        step();
        settle();
        chk_all_zero("rst");
        step();
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1;
        idle_inputs();
        do_reset();

        // single read from m0 with rvalid ignored while IDLE
        data_rvalid_i = 1'b1; data_rdata_i = 32'h1234_5678;
        settle();
        chk("idle_rvalid.rv0", {31'h0, m0_rvalid_o}, 32'h0);
        chk("idle_rvalid.rd0", m0_rdata_o, 32'h0);
        step();
        data_rvalid_i = 1'b0;
        m0_req_i = 1'b1; m0_addr_i = 32'h0000_0100;
        settle();
        chk("rd.c1_req", {31'h0, data_req_o}, 32'h0);
        step();
        settle();
        chk("rd.c2_req",  {31'h0, data_req_o}, 32'h1);
        chk("rd.c2_addr", data_addr_o, 32'h0000_0100);
        chk("rd.c2_we",   {31'h0, data_we_o}, 32'h0);
        chk("rd.c2_rv0",  {31'h0, m0_rvalid_o}, 32'h0);
        data_rvalid_i = 1'b1; data_rdata_i = 32'hDEAD_BEEF;
        settle();
        chk("rd.rv0",  {31'h0, m0_rvalid_o}, 32'h1);
        chk("rd.rd0",  m0_rdata_o, 32'hDEAD_BEEF);
        chk("rd.rv1",  {31'h0, m1_rvalid_o}, 32'h0);
        chk("rd.rd1",  m1_rdata_o, 32'h0);
        chk("rd.req_on_rvalid", {31'h0, data_req_o}, 32'h1);
        step();
        m0_req_i = 1'b0; data_rvalid_i = 1'b0;
        settle();
        chk_all_zero("rd.after");

        // both ports held: strict alternation starting with m0
        do_reset();
        m0_req_i = 1'b1; m0_addr_i = 32'h0000_0010;
        m1_req_i = 1'b1; m1_addr_i = 32'h0000_0020;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("rr.idle_req", {31'h0, data_req_o}, 32'h0);
            step();
            settle();
            chk("rr.busy_req", {31'h0, data_req_o}, 32'h1);
            chk("rr.addr", data_addr_o, (i % 2 == 0) ? 32'h0000_0010 : 32'h0000_0020);
            data_rvalid_i = 1'b1; data_rdata_i = 32'hC0DE_0000 + 32'(i);
            settle();
            chk("rr.rv0", {31'h0, m0_rvalid_o}, (i % 2 == 0) ? 32'h1 : 32'h0);
            chk("rr.rv1", {31'h0, m1_rvalid_o}, (i % 2 == 0) ? 32'h0 : 32'h1);
            chk("rr.rd",  (i % 2 == 0) ? m0_rdata_o : m1_rdata_o, 32'hC0DE_0000 + 32'(i));
            step();
            data_rvalid_i = 1'b0;
        end
        m0_req_i = 1'b0; m1_req_i = 1'b0;
        step();

        // m1 write; m0 inputs change mid-transaction without disturbing the bus
        do_reset();
        m1_req_i = 1'b1; m1_we_i = 1'b1; m1_be_i = 4'b0011;
        m1_addr_i = 32'h0000_0200; m1_wdata_i = 32'h0000_A5A5;
        step();
        m0_req_i = 1'b1; m0_we_i = 1'b1; m0_be_i = 4'hF;
        m0_addr_i = 32'h0000_0300; m0_wdata_i = 32'hFFFF_FFFF;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("wr.we",    {31'h0, data_we_o}, 32'h1);
            chk("wr.be",    {28'h0, data_be_o}, 32'h3);
            chk("wr.addr",  data_addr_o, 32'h0000_0200);
            chk("wr.wdata", data_wdata_o, 32'h0000_A5A5);
            m0_addr_i = m0_addr_i + 32'h4;
            step();
        end
        data_rvalid_i = 1'b1; data_rdata_i = 32'h0;
        settle();
        chk("wr.rv1", {31'h0, m1_rvalid_o}, 32'h1);
        chk("wr.rv0", {31'h0, m0_rvalid_o}, 32'h0);
        step();
        data_rvalid_i = 1'b0; m1_req_i = 1'b0; m1_we_i = 1'b0;
        settle();
        chk("wr.idle_be", {28'h0, data_be_o}, 32'h0);
        chk("wr.idle_we", {31'h0, data_we_o}, 32'h0);
        step();
        settle();
        chk("wr.next_addr", data_addr_o, 32'h0000_030C);
        chk("wr.next_we",   {31'h0, data_we_o}, 32'h1);
        m0_req_i = 1'b0;
        data_rvalid_i = 1'b1;
        step();
        data_rvalid_i = 1'b0;

        // reset in the second BUSY cycle abandons the transaction
        do_reset();
        m0_req_i = 1'b1; m0_addr_i = 32'h0000_0040;
        step();
        step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0; m0_req_i = 1'b0;
        data_rvalid_i = 1'b1; data_rdata_i = 32'hBAD0_BAD0;
        settle();
        chk("rstbusy.req", {31'h0, data_req_o}, 32'h0);
        chk("rstbusy.rv0", {31'h0, m0_rvalid_o}, 32'h0);
        chk("rstbusy.rv1", {31'h0, m1_rvalid_o}, 32'h0);
        chk("rstbusy.rd0", m0_rdata_o, 32'h0);
        step();
        data_rvalid_i = 1'b0;
        settle();
        chk("rstbusy.req2", {31'h0, data_req_o}, 32'h0);

`ifdef MIRISCV_DARB_TIMEOUT_EN
        // rvalid withheld: timeout response on BUSY cycle 8
        do_reset();
        m0_req_i = 1'b1; m0_addr_i = 32'h0000_0500;
        step();
        for (int c = 1; c < 8; c++) begin
            settle();
            chk("to.pre_err", {31'h0, err_o}, 32'h0);
            chk("to.pre_rv0", {31'h0, m0_rvalid_o}, 32'h0);
            step();
        end
        settle();
        chk("to.rv0", {31'h0, m0_rvalid_o}, 32'h1);
        chk("to.rd0", m0_rdata_o, 32'h0);
        chk("to.err", {31'h0, err_o}, 32'h1);
        step();
        m0_req_i = 1'b0;
        settle();
        chk("to.idle_req", {31'h0, data_req_o}, 32'h0);
        chk("to.idle_err", {31'h0, err_o}, 32'h0);

        // rvalid coincides with the timeout cycle: normal response wins
        do_reset();
        m0_req_i = 1'b1; m0_addr_i = 32'h0000_0600;
        step();
        for (int c = 1; c < 8; c++) begin
            step();
        end
        data_rvalid_i = 1'b1; data_rdata_i = 32'h5555_AAAA;
        settle();
        chk("to8.rv0", {31'h0, m0_rvalid_o}, 32'h1);
        chk("to8.rd0", m0_rdata_o, 32'h5555_AAAA);
        chk("to8.err", {31'h0, err_o}, 32'h0);
        step();
        m0_req_i = 1'b0; data_rvalid_i = 1'b0;
`else
        // without the timeout feature BUSY waits indefinitely
        do_reset();
        m0_req_i = 1'b1; m0_addr_i = 32'h0000_0500;
        step();
        for (int c = 1; c <= 12; c++) begin
            settle();
            chk("wait.req", {31'h0, data_req_o}, 32'h1);
            chk("wait.err", {31'h0, err_o}, 32'h0);
            chk("wait.rv0", {31'h0, m0_rvalid_o}, 32'h0);
            step();
        end
        data_rvalid_i = 1'b1; data_rdata_i = 32'h5555_AAAA;
        settle();
        chk("wait.rd0", m0_rdata_o, 32'h5555_AAAA);
        chk("wait.err_end", {31'h0, err_o}, 32'h0);
        step();
        m0_req_i = 1'b0; data_rvalid_i = 1'b0;
`endif
        settle();
        chk("end.req", {31'h0, data_req_o}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/miriscv_data_arbiter.md
MIRISCV_DATA_ARBITER -- requirements
Module: miriscv_data_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default miriscv_pkg::XLEN (32), data/address width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, response-timeout limit (used only when the timeout feature is compiled in).
REQ-003 SHALL have port clk_i  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports mN_req_i/mN_we_i  input  1 each, for N = 0 (core LSU) and N = 1 (debug/DMA); mN_req_i is the request and mN_we_i selects write.
REQ-006 SHALL have ports mN_be_i  input  XLEN/8, mN_addr_i  input  XLEN, mN_wdata_i  input  XLEN, for N = 0, 1.
REQ-007 SHALL have ports mN_rvalid_o  output  1 and mN_rdata_o  output  XLEN, for N = 0, 1; the response to requester N.
REQ-008 SHALL have downstream ports data_req_o, data_we_o  output  1; data_be_o  output  XLEN/8; data_addr_o, data_wdata_o  output  XLEN.
REQ-009 SHALL have downstream ports data_rvalid_i  input  1 and data_rdata_i  input  XLEN.
REQ-010 SHALL have port err_o  output  1  one-cycle timeout-error pulse.

Function
REQ-011 Protocol: a requester holds req and its attributes stable until it sees its rvalid; downstream data_req_o is held until data_rvalid_i.
REQ-012 FSM states: IDLE and BUSY. IDLE->BUSY on any mN_req_i=1. BUSY->IDLE on data_rvalid_i=1 or on timeout.
REQ-013 In IDLE, the arbiter SHALL pick the owner: if only one port requests, that port wins; if both request, the port other than last_owner wins (round-robin).
REQ-014 On the IDLE->BUSY edge, the arbiter SHALL register owner, we, be, addr and wdata; downstream outputs come only from these registers.
REQ-015 data_req_o SHALL be 1 exactly while in BUSY, including the data_rvalid_i cycle; it is 0 in IDLE.
REQ-016 When data_rvalid_i=1 in BUSY, the arbiter SHALL drive the owner's mN_rvalid_o=1 and mN_rdata_o=data_rdata_i in the same cycle (combinational); the other port's rvalid stays 0.
REQ-017 Handoff: last_owner <= owner on the BUSY->IDLE edge.
REQ-018 A request held in the cycle after rvalid counts as a new request.
REQ-019 Minimum transaction is 2 cycles (grant, then BUSY with rvalid); at least one IDLE cycle separates transactions.
REQ-020 data_rvalid_i in IDLE SHALL be ignored: no mN_rvalid_o and no state change.
REQ-021 mN_rdata_o SHALL be 0 whenever mN_rvalid_o=0.
REQ-022 data_be_o/data_addr_o/data_wdata_o/data_we_o SHALL be 0 in IDLE.

Reset
REQ-023 On rst_i=1 at a clock edge: state=IDLE, last_owner=1 (port 0 wins the first tie), registered attributes=0, timeout counter=0.
REQ-024 During and after reset, all outputs SHALL be 0 (data_req_o, mN_rvalid_o, mN_rdata_o, err_o, and all downstream attributes).
REQ-025 Reset during BUSY SHALL abandon the transaction: data_req_o=0 from the next cycle, and a late data_rvalid_i is ignored per REQ-020.

Configuration
REQ-026 Macro MIRISCV_DARB_TIMEOUT_EN defined: a counter clears on entry to BUSY and increments each BUSY cycle without data_rvalid_i.
REQ-027 When that counter reaches TIMEOUT_CYCLES, the arbiter SHALL, in that cycle, drive the owner's mN_rvalid_o=1 with mN_rdata_o=0 and err_o=1, then go to IDLE.
REQ-028 If data_rvalid_i and timeout coincide, data_rvalid_i wins: normal response, err_o=0.
REQ-029 Macro undefined: no counter, err_o tied 0, BUSY waits indefinitely.

Structure
REQ-030 Package miriscv_darb_pkg SHALL hold the state enum darb_state_e (DARB_IDLE, DARB_BUSY) and the constant DARB_N_PORTS=2.
REQ-031 The 2-way round-robin pick SHALL be a sub-module miriscv_rr_arbiter: inputs req[1:0] and last; output one-hot gnt; purely combinational.
REQ-032 Estimated RTL size: 150-250 lines total.

Verification
REQ-033 After reset, m0 reads addr 0x100 -> data_req_o rises on cycle 2 with data_addr_o=0x100; memory returns rvalid with 0xDEADBEEF -> m0_rvalid_o=1 and m0_rdata_o=0xDEADBEEF in the same cycle; m1_rvalid_o stays 0.
REQ-034 m0 and m1 request in the same cycle, both held -> grant order m0, m1, m0, m1 over 4 transactions, with one IDLE cycle between them.
REQ-035 m1 writes be=4'b0011, wdata=0x0000A5A5 to 0x200 while m0 changes its inputs mid-transaction -> downstream attributes stay constant until rvalid.
REQ-036 Assert rst_i in the 2nd BUSY cycle, then pulse data_rvalid_i -> data_req_o=0 from the next cycle and no mN_rvalid_o.
REQ-037 With MIRISCV_DARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, withhold rvalid -> on the 8th BUSY cycle m0_rvalid_o=1, m0_rdata_o=0, err_o=1; the next cycle is IDLE.
REQ-038 With TIMEOUT_CYCLES=8, rvalid arrives on BUSY cycle 8 -> normal data returned and err_o=0.
